// File: rtl/cntr_pkg.sv
// Shared constants and next-count selection encoding for the up/down modulo counter.
package cntr_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic [2:0] {
        HOLD,
        LOAD,
        INC,
        DEC,
        WRAP_LO,
        WRAP_HI,
        CLAMP
    } next_sel_e;

endpackage

// File: rtl/cntr_prescaler.sv
// Counts enabled cycles and emits a one-cycle tick on every PRESCALE-th one.
module cntr_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/updn_mod_cntr.sv
// Up/down modulo counter with programmable limit, load, wrap/saturate and tc/ovf flags.
// Define CNTR_PRESCALE_EN to step only on every PRESCALE-th enabled cycle.
module updn_mod_cntr
    import cntr_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    if ((PRESCALE < 1) || (PRESCALE > 256)) begin : g_bad_prescale
        $error("updn_mod_cntr: PRESCALE must be in 1..256");
    end

    logic tick;

`ifdef CNTR_PRESCALE_EN
    cntr_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );
`else
    assign tick = 1'b1;
`endif

    next_sel_e        sel;
    logic             boundary;
    logic [WIDTH-1:0] next_count;

    // NOTE: defaults come first so every path assigns sel and boundary; no latch is inferred.
    always_comb begin
        sel      = HOLD;
        boundary = 1'b0;
        if (load) begin
            sel = LOAD;
        end else if (en && tick) begin
            if (dir == DIR_UP) begin
                if (count < limit) begin
                    sel = INC;
                end else begin
                    boundary = 1'b1;
                    sel      = (sat_mode == MODE_SAT) ? CLAMP : WRAP_LO;
                end
            end else begin
                if (count > limit) begin
                    sel = CLAMP;
                end else if (count != '0) begin
                    sel = DEC;
                end else begin
                    boundary = 1'b1;
                    sel      = (sat_mode == MODE_SAT) ? WRAP_LO : WRAP_HI;
                end
            end
        end
    end

    always_comb begin
        next_count = count;
        unique case (sel)
            LOAD:    next_count = (load_val > limit) ? limit : load_val;
            INC:     next_count = count + 1'b1;
            DEC:     next_count = count - 1'b1;
            WRAP_LO: next_count = '0;
            WRAP_HI: next_count = limit;
            CLAMP:   next_count = limit;
            default: next_count = count;
        endcase
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= next_count;
            tc    <= boundary;
            if (boundary) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_updn_mod_cntr.sv
// Scoreboard bench for updn_mod_cntr: stimulus pushes expected post-edge state, a monitor checks it.
module tb_updn_mod_cntr;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             dir = 1'b1;
    logic             sat_mode = 1'b0;
    logic [WIDTH-1:0] limit = '0;
    logic             clr_ovf = 1'b0;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    typedef struct {
        logic [WIDTH-1:0] count;
        logic             tc;
        logic             ovf;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    updn_mod_cntr #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .sat_mode (sat_mode),
        .limit    (limit),
        .clr_ovf  (clr_ovf),
        .count    (count),
        .tc       (tc),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // One clock of stimulus; the expected registered outputs after the next edge go to the scoreboard.
    task automatic cyc(input logic e, input logic ld, input logic [WIDTH-1:0] lv,
                       input logic d, input logic sm, input logic [WIDTH-1:0] lim,
                       input logic co, input logic [WIDTH-1:0] ec, input logic et,
                       input logic eo, input string name);
        exp_t x;
        @(negedge clk);
        en = e; load = ld; load_val = lv; dir = d; sat_mode = sm; limit = lim; clr_ovf = co;
        x.count = ec; x.tc = et; x.ovf = eo; x.name = name;
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                check({x.name, ".count"}, 32'(count), 32'(x.count));
                check({x.name, ".tc"},    32'(tc),    32'(x.tc));
                check({x.name, ".ovf"},   32'(ovf),   32'(x.ovf));
            end
        end
    end

    initial begin : stimulus
        #3;
        check("reset.count", 32'(count), 32'd0);
        check("reset.tc",    32'(tc),    32'd0);
        check("reset.ovf",   32'(ovf),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Count up to 5, then assert reset between edges.
        for (int i = 1; i <= 5; i++)
            cyc(1, 0, 0, 1, 0, 10, 0, 8'(i), 0, 0, "pre_rst");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst.count", 32'(count), 32'd0);
        check("async_rst.tc",    32'(tc),    32'd0);
        check("async_rst.ovf",   32'(ovf),   32'd0);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b0;

        // Up wrap, limit 3.
        cyc(1, 0, 0, 1, 0, 3, 0, 1, 0, 0, "upwrap1");
        cyc(1, 0, 0, 1, 0, 3, 0, 2, 0, 0, "upwrap2");
        cyc(1, 0, 0, 1, 0, 3, 0, 3, 0, 0, "upwrap3");
        cyc(1, 0, 0, 1, 0, 3, 0, 0, 1, 1, "upwrap0");
        cyc(1, 0, 0, 1, 0, 3, 0, 1, 0, 1, "upwrap_after");

        // Down saturate with ovf clear behaviour; load also honours clr_ovf.
        cyc(1, 1, 2, 0, 1, 3, 1, 2, 0, 0, "dsat_load");
        cyc(1, 0, 0, 0, 1, 3, 0, 1, 0, 0, "dsat1");
        cyc(1, 0, 0, 0, 1, 3, 0, 0, 0, 0, "dsat0");
        cyc(1, 0, 0, 0, 1, 3, 0, 0, 1, 1, "dsat_hold_a");
        cyc(1, 0, 0, 0, 1, 3, 1, 0, 1, 1, "dsat_set_wins");
        cyc(0, 0, 0, 0, 1, 3, 1, 0, 0, 0, "dsat_clr_idle");

        // Load clamps to limit and overrides en; next step wraps.
        cyc(1, 1, 200, 1, 0, 10, 0, 10, 0, 0, "load_clamp");
        cyc(1, 0, 0,   1, 0, 10, 0, 0,  1, 1, "load_then_wrap");

        // Limit shrink below the current count.
        cyc(0, 1, 9, 0, 0, 10, 1, 9, 0, 0, "shrink_load_a");
        cyc(1, 0, 0, 0, 0, 4,  0, 4, 0, 0, "shrink_down");
        cyc(0, 1, 9, 0, 0, 10, 0, 9, 0, 0, "shrink_load_b");
        cyc(1, 0, 0, 1, 0, 4,  0, 0, 1, 1, "shrink_up");

        // limit=0 pins count; every enabled step is a boundary.
        cyc(1, 0, 0, 1, 0, 0, 1, 0, 1, 1, "lim0_up");
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 1, 1, "lim0_down_sat");
        cyc(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, "lim0_idle");

        // Down wrap from 0 to limit, up saturate at limit, full-range wrap.
        cyc(1, 0, 0, 0, 0, 5, 0, 5, 1, 1, "down_wrap");
        cyc(1, 0, 0, 0, 0, 5, 1, 4, 0, 0, "down_step_clr");
        cyc(1, 1, 3, 1, 1, 3, 0, 3, 0, 0, "upsat_load");
        cyc(1, 0, 0, 1, 1, 3, 0, 3, 1, 1, "upsat_hold");
        cyc(1, 1, 255, 1, 0, 255, 1, 255, 0, 0, "full_load");
        cyc(1, 0, 0,   1, 0, 255, 0, 0,   1, 1, "full_wrap");

`ifdef CNTR_PRESCALE_EN
        // PRESCALE=4: steps after every 4th enabled cycle, gaps freeze, load restarts.
        cyc(0, 1, 0, 1, 0, 255, 1, 0, 0, 0, "ps_load");
        for (int i = 1; i <= 12; i++) begin
            if (i == 5) begin
                cyc(0, 0, 0, 1, 0, 255, 0, 1, 0, 0, "ps_gap");
                cyc(0, 0, 0, 1, 0, 255, 0, 1, 0, 0, "ps_gap");
            end
            cyc(1, 0, 0, 1, 0, 255, 0, 8'(i / 4), 0, 0, "ps_run");
        end
        cyc(1, 0, 0, 1, 0, 255, 0, 3, 0, 0, "ps_pre_load");
        cyc(1, 0, 0, 1, 0, 255, 0, 3, 0, 0, "ps_pre_load");
        cyc(1, 1, 3, 1, 0, 255, 0, 3, 0, 0, "ps_reload");
        for (int i = 1; i <= 4; i++)
            cyc(1, 0, 0, 1, 0, 255, 0, (i == 4) ? 8'd4 : 8'd3, 0, 0, "ps_fresh");
`endif

        @(negedge clk);
        en = 1'b0;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/updn_mod_cntr.md
Name: updn_mod_cntr

Overview:
Parametrised up/down modulo counter; the successor to the plain enable counter. Adds the following:
- runtime-programmable terminal value (`limit`)
- direction control
- synchronous parallel load
- wrap or saturate mode
- registered terminal-count pulse and sticky overflow flag
It sits in datapath control as a loop/address/timeout counter and drives sequencers from `tc`.

Parameters:
WIDTH, 8, bit width of count, limit and load_val
PRESCALE, 4, enabled cycles per count step when CNTR_PRESCALE_EN is defined (legal range 1..256); ignored otherwise

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  count enable; one step per enabled cycle (or per prescaled tick)
load  input  1  synchronous parallel load, overrides en
load_val  input  WIDTH  value loaded on load
dir  input  1  1 = count up, 0 = count down
sat_mode  input  1  0 = wrap at boundary, 1 = saturate (hold) at boundary
limit  input  WIDTH  terminal value; count range is 0..limit inclusive
clr_ovf  input  1  synchronous clear of ovf
count  output  WIDTH  current count (registered)
tc  output  1  registered one-cycle terminal-count pulse
ovf  output  1  sticky boundary-hit flag

Behaviour:
- Reset (async, rst=1): count=0, tc=0, ovf=0, prescaler=0. Asynchronous assertion; release takes effect at the next clock.
- Priority per edge: rst > load > en. With load=0 and en=0, count holds and tc=0.
- load=1: count <= min(load_val, limit). tc=0. Prescaler cleared. ovf unaffected, except that clr_ovf still applies.
- Step (en=1, load=0, tick=1), up (dir=1):
  - count < limit: count+1.
  - count >= limit (boundary): wrap -> 0; sat -> limit.
- Step, down (dir=0):
  - count > limit: count <= limit, not a boundary.
  - 0 < count <= limit: count-1.
  - count == 0 (boundary): wrap -> limit; sat -> 0.
- tc: asserted for exactly the one cycle after an edge that took a boundary step, in both modes. In sat mode, repeated enabled steps at the boundary re-pulse tc each step.
- ovf: set on any boundary step; cleared by clr_ovf. Set and clear on the same edge: set wins.
- limit=0: count pinned at 0. Every enabled step is a boundary, so tc=1 every cycle after an enabled step.
- Arithmetic is modulo 2^WIDTH internally. No intermediate may exceed WIDTH bits; comparisons are unsigned.
- limit or dir changing mid-count: takes effect on the next step; no history is kept.

Optional Feature:
CNTR_PRESCALE_EN
- Defined:
  - An internal prescaler counts enabled cycles; tick=1 on every PRESCALE-th enabled cycle, then the prescaler returns to 0.
  - Disabled cycles freeze the prescaler.
  - load and rst clear the prescaler.
  - PRESCALE=1 behaves identically to the undefined case.
- Undefined: tick is tied to 1; every enabled cycle steps; no prescaler registers exist.

Decomposition:
- Package cntr_pkg holds:
  - constants DIR_DOWN=1'b0, DIR_UP=1'b1, MODE_WRAP=1'b0, MODE_SAT=1'b1
  - the next-count selection enum {HOLD, LOAD, INC, DEC, WRAP_LO, WRAP_HI, CLAMP}
- One sub-module, cntr_prescaler (parameter PRESCALE; ports clk, rst, en, clr, tick), instantiated only under CNTR_PRESCALE_EN.
- Boundary/next-value logic stays inline.

Test Plan:
1. Async reset mid-count: count=5, assert rst between edges -> count=0, tc=0, ovf=0 immediately, before the next edge.
2. Up wrap: WIDTH=8, limit=3, dir=1, sat_mode=0, en=1 from 0 -> count 1,2,3,0,1. tc=1 only in the cycle count shows 0; ovf=1 thereafter.
3. Down sat plus clear: limit=3, load 2, dir=0, sat_mode=1 -> count 1,0,0,0. tc pulses on each step taken at 0. clr_ovf asserted with a boundary step -> ovf stays 1; clr_ovf on a hold cycle -> ovf=0.
4. Load clamp and priority: limit=10, load=1, en=1, load_val=200 -> count=10, tc=0. Next edge with load=0, dir=1 -> count=0 (wrap), tc=1.
5. Limit shrink: count=9, limit changed to 4.
   - dir=0, one step -> count=4, tc=0.
   - dir=1 from 9 instead -> count=0, tc=1.
6. CNTR_PRESCALE_EN, PRESCALE=4, limit=255, en=1 for 12 cycles -> count=3, with steps after enabled cycles 4, 8 and 12. en dropped for 2 cycles mid-way -> steps delayed by 2. load mid-prescale -> next step needs 4 fresh enabled cycles.
